// File: rtl/sle4_debounce_pkg.sv
// Shared constants and helpers for the SLE4 debounce block.
package sle4_debounce_pkg;

  // Width of the run counter and of the EVENTS counter.
  localparam int CNT_W = 4;

  // Largest legal debounce length; it must fit in the run counter.
  localparam int N_MAX = 15;

  // EVENTS stops counting at this value instead of wrapping.
  localparam logic [CNT_W-1:0] EVENTS_SAT = 4'd15;

  // Saturating increment used for the transition counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == EVENTS_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sle4_debounce_sle4.sv
// Combinational signed 4-bit less-or-equal comparator: le_o = (i0 <= i1).
module sle4_debounce_sle4
  import sle4_debounce_pkg::*;
(
  input  logic [CNT_W-1:0] i0_i,
  input  logic [CNT_W-1:0] i1_i,
  output logic             le_o
);

  // Two's complement compare; the operands are reinterpreted as signed.
  always_comb begin
    le_o = ($signed(i0_i) <= $signed(i1_i));
  end

endmodule

// File: rtl/sle4_debounce.sv
// Debounced threshold flag built on the SLE4 comparator. The state O flips
// only after N consecutive valid samples disagree with it; each flip produces
// a one-cycle RISE or FALL pulse and bumps a saturating transition count.
module sle4_debounce
  import sle4_debounce_pkg::*;
#(
  // Consecutive disagreeing valid samples needed to flip; legal range 1..N_MAX.
  parameter int N = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [CNT_W-1:0] i_i,
  input  logic [CNT_W-1:0] t_i,
  input  logic             clr_i,
  output logic             o_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] events_o
);

  // Run length at which the next disagreeing sample causes a flip.
  localparam logic [CNT_W-1:0] FLIP_AT = CNT_W'(N - 1);

  logic             raw;
  logic             o_q,      o_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic [CNT_W-1:0] events_q, events_d;

  sle4_debounce_sle4 u_sle4 (
    .i0_i (i_i),
    .i1_i (t_i),
    .le_o (raw)
  );

  // Next-state: count disagreeing valid samples, flip on the N-th one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    o_d      = o_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    events_d = events_q;

    if (valid_i) begin
      if (raw == o_q) begin
        // An agreeing sample ends any run in progress.
        cnt_d = '0;
      end else if (cnt_q == FLIP_AT) begin
        o_d      = raw;
        cnt_d    = '0;
        rise_d   = raw;
        fall_d   = ~raw;
        events_d = sat_inc(events_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Clear takes priority over a same-cycle increment.
    if (clr_i) begin
      events_d = '0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      o_q      <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      events_q <= '0;
    end else begin
      o_q      <= o_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      events_q <= events_d;
    end
  end

  assign o_o      = o_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign events_o = events_q;

endmodule

// File: tb/tb_sle4_debounce.sv
// Self-checking bench for sle4_debounce: an N=3 and an N=1 instance share
// the same stimulus and are compared against a behavioural model every cycle,
// plus hand-derived vectors for the directed scenarios.
module tb_sle4_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] i_s = '0;
  logic [3:0] t_s = '0;
  logic       clr = 1'b0;

  logic       o_w      [2];
  logic       rise_w   [2];
  logic       fall_w   [2];
  logic [3:0] events_w [2];

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state, index 0 -> N=3, index 1 -> N=1.
  int n_of   [2] = '{3, 1};
  int m_o    [2];
  int m_run  [2];
  int m_ev   [2];
  int m_rise [2];
  int m_fall [2];

  always #5 clk = ~clk;

  sle4_debounce #(.N(3)) dut3 (
    .clk_i    (clk),
    .reset_i  (reset),
    .valid_i  (valid),
    .i_i      (i_s),
    .t_i      (t_s),
    .clr_i    (clr),
    .o_o      (o_w[0]),
    .rise_o   (rise_w[0]),
    .fall_o   (fall_w[0]),
    .events_o (events_w[0])
  );

  sle4_debounce #(.N(1)) dut1 (
    .clk_i    (clk),
    .reset_i  (reset),
    .valid_i  (valid),
    .i_i      (i_s),
    .t_i      (t_s),
    .clr_i    (clr),
    .o_o      (o_w[1]),
    .rise_o   (rise_w[1]),
    .fall_o   (fall_w[1]),
    .events_o (events_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer compare of the signed values, run length per instance.
  task automatic model_update();
    int si, ti, raw;
    si  = $signed(i_s);
    ti  = $signed(t_s);
    raw = (si <= ti) ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_o[d] = 0; m_run[d] = 0; m_ev[d] = 0; m_rise[d] = 0; m_fall[d] = 0;
      end else begin
        m_rise[d] = 0;
        m_fall[d] = 0;
        if (valid) begin
          if (raw == m_o[d]) begin
            m_run[d] = 0;
          end else begin
            m_run[d]++;
            if (m_run[d] == n_of[d]) begin
              m_o[d]    = raw;
              m_run[d]  = 0;
              m_rise[d] = raw;
              m_fall[d] = 1 - raw;
              m_ev[d]   = (m_ev[d] < 15) ? m_ev[d] + 1 : 15;
            end
          end
        end
        if (clr) m_ev[d] = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, update model on the rising edge,
  // sample just after it.
  task automatic step(input logic rst, input logic v, input int ii, input int tt,
                      input logic c);
    @(negedge clk);
    reset = rst;
    valid = v;
    i_s   = 4'(ii);
    t_s   = 4'(tt);
    clr   = c;
    @(posedge clk);
    model_update();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("model_o[N=%0d]", n_of[d]),      int'(o_w[d]),      m_o[d]);
      check($sformatf("model_rise[N=%0d]", n_of[d]),   int'(rise_w[d]),   m_rise[d]);
      check($sformatf("model_fall[N=%0d]", n_of[d]),   int'(fall_w[d]),   m_fall[d]);
      check($sformatf("model_events[N=%0d]", n_of[d]), int'(events_w[d]), m_ev[d]);
      check($sformatf("pulse_excl[N=%0d]", n_of[d]),   int'(rise_w[d] & fall_w[d]), 0);
    end
  endtask

  task automatic expect_dut(input string name, input int d, input int o, input int r,
                            input int f, input int ev);
    check({name, "_o"},      int'(o_w[d]),      o);
    check({name, "_rise"},   int'(rise_w[d]),   r);
    check({name, "_fall"},   int'(fall_w[d]),   f);
    check({name, "_events"}, int'(events_w[d]), ev);
  endtask

  typedef struct {
    logic rst;
    logic v;
    int   i;
    int   t;
    logic c;
    int   o;
    int   r;
    int   f;
    int   ev;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic v, input int i, input int t,
                              input logic c, input int o, input int r, input int f,
                              input int ev);
    vec_t x;
    x.rst = rst; x.v = v; x.i = i; x.t = t; x.c = c;
    x.o = o; x.r = r; x.f = f; x.ev = ev;
    return x;
  endfunction

  initial begin
    vec_t vecs [29];
    int   raw;
    int   ev;

    // Expected outputs of the N=3 instance after each cycle.
    vecs[0]  = mk(1, 1, -8,  7, 0, 0, 0, 0, 0);  // reset with a disagreeing sample
    vecs[1]  = mk(1, 1, -8,  7, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1,  2,  5, 0, 0, 0, 0, 0);  // rise run, 1
    vecs[3]  = mk(0, 1,  2,  5, 0, 0, 0, 0, 0);  // 2
    vecs[4]  = mk(0, 1,  2,  5, 0, 1, 1, 0, 1);  // 3 -> flip
    vecs[5]  = mk(0, 0,  0,  0, 0, 1, 0, 0, 1);  // pulse gone
    vecs[6]  = mk(0, 1,  6,  5, 0, 1, 0, 0, 1);  // interrupted run
    vecs[7]  = mk(0, 1,  6,  5, 0, 1, 0, 0, 1);
    vecs[8]  = mk(0, 1,  5,  5, 0, 1, 0, 0, 1);  // equal: agrees, run reset
    vecs[9]  = mk(0, 1,  6,  5, 0, 1, 0, 0, 1);
    vecs[10] = mk(0, 1,  6,  5, 0, 1, 0, 0, 1);
    vecs[11] = mk(0, 1,  6,  5, 0, 0, 0, 1, 2);  // fall
    vecs[12] = mk(0, 1, -3, -3, 0, 0, 0, 0, 2);  // gapped run, 1
    vecs[13] = mk(0, 0,  7, -8, 0, 0, 0, 0, 2);  // idle: inputs ignored
    vecs[14] = mk(0, 0,  7, -8, 0, 0, 0, 0, 2);
    vecs[15] = mk(0, 1, -1,  0, 0, 0, 0, 0, 2);  // 2
    vecs[16] = mk(0, 0,  0,  0, 0, 0, 0, 0, 2);
    vecs[17] = mk(0, 1,  0,  0, 0, 1, 1, 0, 3);  // 3 -> rise
    vecs[18] = mk(0, 0,  0,  0, 0, 1, 0, 0, 3);
    vecs[19] = mk(0, 0,  0,  0, 1, 1, 0, 0, 0);  // clear while idle
    vecs[20] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0);  // reset
    vecs[21] = mk(0, 1, -8,  7, 0, 0, 0, 0, 0);  // partial run
    vecs[22] = mk(0, 1, -8,  7, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, 1, -8,  7, 0, 0, 0, 0, 0);  // reset mid-run
    vecs[24] = mk(0, 1, -8,  7, 0, 0, 0, 0, 0);  // count restarts at 1
    vecs[25] = mk(0, 1, -8,  7, 0, 0, 0, 0, 0);
    vecs[26] = mk(0, 1, -8,  7, 0, 1, 1, 0, 1);
    vecs[27] = mk(0, 1,  7, -8, 0, 1, 0, 0, 1);
    vecs[28] = mk(0, 1,  7, -8, 0, 1, 0, 0, 1);

    for (int k = 0; k < 29; k++) begin
      step(vecs[k].rst, vecs[k].v, vecs[k].i, vecs[k].t, vecs[k].c);
      expect_dut($sformatf("vec%0d", k), 0, vecs[k].o, vecs[k].r, vecs[k].f, vecs[k].ev);
    end

    // N=1 signed boundaries.
    step(1, 0, 0, 0, 0);
    expect_dut("n1_reset", 1, 0, 0, 0, 0);
    step(0, 1, 7, -8, 0);
    expect_dut("n1_7le-8", 1, 0, 0, 0, 0);
    step(0, 1, -8, 7, 0);
    expect_dut("n1_-8le7", 1, 1, 1, 0, 1);
    step(0, 1, 7, -8, 0);
    expect_dut("n1_fall", 1, 0, 0, 1, 2);

    // N=1 saturation: 20 more flips, EVENTS stops at 15.
    ev = 2;
    for (int k = 0; k < 20; k++) begin
      raw = (k % 2 == 0) ? 1 : 0;
      if (raw == 1) step(0, 1, -8, 7, 0);
      else          step(0, 1, 7, -8, 0);
      ev = (ev < 15) ? ev + 1 : 15;
      expect_dut($sformatf("n1_toggle%0d", k), 1, raw, raw, 1 - raw, ev);
    end

    // Clear on a flip cycle wins over the increment; the pulse still fires.
    step(0, 1, -8, 7, 1);
    expect_dut("n1_clr_flip", 1, 1, 1, 0, 0);
    step(0, 1, 7, -8, 0);
    expect_dut("n1_after_clr", 1, 0, 0, 1, 1);
    step(1, 1, -8, 7, 1);
    expect_dut("n1_reset_mid", 1, 0, 0, 0, 0);

    // Randomized traffic against the model, both instances.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
